// File: rtl/sound_sequencer_pkg.sv
// Shared definitions for the note-list sequencer.
//   - default widths for the tone divider, volume sample and duration field
//   - queue depth and tick prescaler defaults
//   - FSM state encoding (2-bit) used by the sequencer and its debug port
package sound_sequencer_pkg;

  localparam int DEF_TONE_DIV_WIDTH = 14;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_DUR_WIDTH      = 8;
  localparam int DEF_DEPTH_LOG2     = 3;
  localparam int DEF_TICK_LOG2      = 13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } seq_state_t;

  // Any state other than IDLE counts as "sequencer busy".
  function automatic logic is_active(input seq_state_t s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/sound_sequencer_note_fifo.sv
// Synchronous show-ahead FIFO holding queued notes.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_wr_data  write request and data; ignored when full or flushing
//   i_pop            read request; ignored when empty or flushing
//   i_flush          empties the queue on the next edge (highest priority)
//   o_rd_data        head entry, valid whenever o_empty is low
//   o_full, o_empty, o_level  occupancy status
// Handshake: a push is taken on an edge where i_push=1 and o_full=0; a pop
// is taken on an edge where i_pop=1 and o_empty=0. Both may happen on the
// same edge, leaving o_level unchanged.
module sound_sequencer_note_fifo #(
  parameter int WIDTH      = 38,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_do_push = i_push && !o_full  && !i_flush;
  assign w_do_pop  = i_pop  && !o_empty && !i_flush;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;

endmodule

// File: rtl/sound_sequencer.sv
// Note-list sequencer feeding the square-tone generator (tone_div, vol).
// The CPU pushes {tone_div, vol, dur} notes; a start pulse plays the queue
// back to back with a one-tick silent gap after each note.
// Ports:
//   bit_clk, reset_n           clock, asynchronous active-low reset
//   wr_en, wr_tone_div, wr_vol, wr_dur   note push (dur=0 means 2**DUR_WIDTH ticks)
//   start, stop                playback control pulses; stop wins
//   tone_div, vol              registered tone generator controls
//   busy, note_done            playback status (note_done pulses after each gap)
//   full, empty, level, overflow   queue status; overflow is sticky
//   dbg_state                  current FSM state for observation
module sound_sequencer
  import sound_sequencer_pkg::*;
#(
  parameter int TONE_DIV_WIDTH = DEF_TONE_DIV_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int DUR_WIDTH      = DEF_DUR_WIDTH,
  parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
  parameter int TICK_LOG2      = DEF_TICK_LOG2
) (
  input  logic                      bit_clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [TONE_DIV_WIDTH-1:0] wr_tone_div,
  input  logic [DATA_WIDTH-1:0]     wr_vol,
  input  logic [DUR_WIDTH-1:0]      wr_dur,
  input  logic                      start,
  input  logic                      stop,
  output logic [TONE_DIV_WIDTH-1:0] tone_div,
  output logic [DATA_WIDTH-1:0]     vol,
  output logic                      busy,
  output logic                      note_done,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH_LOG2:0]       level,
  output logic                      overflow,
  output seq_state_t                dbg_state
);

  localparam int FW = TONE_DIV_WIDTH + DATA_WIDTH + DUR_WIDTH;

  seq_state_t                r_state;
  seq_state_t                w_state_nxt;
  logic [TONE_DIV_WIDTH-1:0] r_tone_div;
  logic [DATA_WIDTH-1:0]     r_vol;
  logic                      r_busy;
  logic                      r_note_done;
  logic                      r_overflow;
  logic [TICK_LOG2-1:0]      r_presc;
  logic [DUR_WIDTH:0]        r_dur_cnt;   // one extra bit to hold 2**DUR_WIDTH

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [DEPTH_LOG2:0]       w_level;
  logic [FW-1:0]             w_head;
  logic [TONE_DIV_WIDTH-1:0] w_head_tone;
  logic [DATA_WIDTH-1:0]     w_head_vol;
  logic [DUR_WIDTH-1:0]      w_head_dur;
  logic                      w_tick_end;
  logic                      w_last_tick;
  logic                      w_gap_exit;

  assign w_push = wr_en && !w_full && !stop;
  // The head is popped on the LOAD edge, the same edge that latches it.
  assign w_pop  = (r_state == S_LOAD) && !stop;

  sound_sequencer_note_fifo #(
    .WIDTH      (FW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk     (bit_clk),
    .i_rst_n   (reset_n),
    .i_push    (w_push),
    .i_wr_data ({wr_tone_div, wr_vol, wr_dur}),
    .i_pop     (w_pop),
    .i_flush   (stop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  assign {w_head_tone, w_head_vol, w_head_dur} = w_head;

  assign w_tick_end  = &r_presc;
  assign w_last_tick = w_tick_end && (r_dur_cnt == (DUR_WIDTH+1)'(1));
  assign w_gap_exit  = (r_state == S_GAP) && w_tick_end;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && !w_empty) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_PLAY;
      S_PLAY: if (w_last_tick) w_state_nxt = S_GAP;
      S_GAP:  if (w_tick_end) w_state_nxt = w_empty ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tone_div  <= '0;
      r_vol       <= '0;
      r_busy      <= 1'b0;
      r_note_done <= 1'b0;
      r_overflow  <= 1'b0;
      r_presc     <= '0;
      r_dur_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // busy follows the state it will be in, so it matches dbg_state.
      r_busy      <= is_active(w_state_nxt);
      r_note_done <= w_gap_exit && !stop;
      if (stop) begin
        r_vol      <= '0;
        r_presc    <= '0;
        r_dur_cnt  <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (wr_en && w_full) r_overflow <= 1'b1;
        case (r_state)
          S_LOAD: begin
            r_tone_div <= w_head_tone;
            r_vol      <= w_head_vol;
            r_dur_cnt  <= (w_head_dur == '0) ? {1'b1, {DUR_WIDTH{1'b0}}}
                                             : {1'b0, w_head_dur};
            r_presc    <= '0;
          end
          S_PLAY: begin
            r_presc <= r_presc + 1'b1;
            if (w_tick_end) r_dur_cnt <= r_dur_cnt - 1'b1;
            if (w_last_tick) r_vol <= '0;
          end
          S_GAP: begin
            r_presc <= r_presc + 1'b1;
          end
          default: begin
            r_presc <= '0;
            r_vol   <= '0;
          end
        endcase
      end
    end
  end

  assign tone_div  = r_tone_div;
  assign vol       = r_vol;
  assign busy      = r_busy;
  assign note_done = r_note_done;
  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = w_level;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sound_sequencer.sv
module tb_sound_sequencer;
  import sound_sequencer_pkg::*;

  localparam int TW = 14;
  localparam int DW = 16;
  localparam int UW = 8;
  localparam int NW = TW + DW + UW;

  logic          bit_clk;
  logic          reset_n;
  logic          wr_en;
  logic [TW-1:0] wr_tone_div;
  logic [DW-1:0] wr_vol;
  logic [UW-1:0] wr_dur;
  logic          start;
  logic          stop;
  logic [TW-1:0] tone_div;
  logic [DW-1:0] vol;
  logic          busy;
  logic          note_done;
  logic          full;
  logic          empty;
  logic [3:0]    level;
  logic          overflow;
  seq_state_t    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [NW-1:0] exp_q[$];

  sound_sequencer #(.TICK_LOG2(2)) dut (
    .bit_clk     (bit_clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_tone_div (wr_tone_div),
    .wr_vol      (wr_vol),
    .wr_dur      (wr_dur),
    .start       (start),
    .stop        (stop),
    .tone_div    (tone_div),
    .vol         (vol),
    .busy        (busy),
    .note_done   (note_done),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    bit_clk = 1'b0;
    forever #5 bit_clk = ~bit_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step(input int n);
    repeat (n) @(posedge bit_clk);
    #1;
  endtask

  task automatic push_note(input logic [TW-1:0] t, input logic [DW-1:0] v, input logic [UW-1:0] d);
    wr_en = 1'b1; wr_tone_div = t; wr_vol = v; wr_dur = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin : main
    logic [NW-1:0] e;
    logic [TW-1:0] e_tone;
    logic [DW-1:0] e_vol;
    logic [UW-1:0] e_dur;
    int            done_cnt;

    reset_n = 1'b0; wr_en = 1'b0; wr_tone_div = '0; wr_vol = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0;
    step(2);
    check("rst_tone_div", 32'(tone_div), 32'd0);
    check("rst_vol", 32'(vol), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    reset_n = 1'b1;
    step(1);

    // 1. reset asserted mid-note
    push_note(14'd55, 16'h2222, 8'd2);
    pulse_start();
    step(3);
    check("t1_playing_tone", 32'(tone_div), 32'd55);
    reset_n = 1'b0;
    #2;
    check("t1_async_tone_div", 32'(tone_div), 32'd0);
    check("t1_async_vol", 32'(vol), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_level", 32'(level), 32'd0);
    check("t1_async_empty", 32'(empty), 32'd1);
    check("t1_async_full", 32'(full), 32'd0);
    check("t1_async_note_done", 32'(note_done), 32'd0);
    #1 reset_n = 1'b1;
    step(1);
    check("t1_idle_after_release", 32'(dbg_state), 32'(S_IDLE));

    // 2. single note {100, 4000, 3}
    push_note(14'd100, 16'h4000, 8'd3);
    check("t2_level_after_push", 32'(level), 32'd1);
    pulse_start();
    check("t2_busy_edge1", 32'(busy), 32'd1);
    check("t2_state_load", 32'(dbg_state), 32'(S_LOAD));
    check("t2_vol_in_load", 32'(vol), 32'd0);
    step(1);
    check("t2_tone_edge2", 32'(tone_div), 32'd100);
    check("t2_vol_edge2", 32'(vol), 32'h4000);
    check("t2_level_popped", 32'(level), 32'd0);
    for (int i = 0; i < 11; i++) begin
      step(1);
      check("t2_vol_hold", 32'(vol), 32'h4000);
    end
    step(1);
    check("t2_gap_vol", 32'(vol), 32'd0);
    check("t2_gap_tone_held", 32'(tone_div), 32'd100);
    check("t2_gap_state", 32'(dbg_state), 32'(S_GAP));
    step(3);
    check("t2_gap_no_done_yet", 32'(note_done), 32'd0);
    step(1);
    check("t2_note_done", 32'(note_done), 32'd1);
    check("t2_busy_low", 32'(busy), 32'd0);
    check("t2_idle", 32'(dbg_state), 32'(S_IDLE));
    step(1);
    check("t2_note_done_one_cycle", 32'(note_done), 32'd0);

    // 3. nine pushes, eight kept
    for (int k = 0; k < 9; k++) begin
      e_tone = 14'(200 + k);
      e_vol  = 16'(16'h1000 * (k + 1));
      e_dur  = 8'((k % 2) + 1);
      if (k < 8) exp_q.push_back({e_tone, e_vol, e_dur});
      if (k == 8) check("t3_full_before_9th", 32'(full), 32'd1);
      push_note(e_tone, e_vol, e_dur);
    end
    check("t3_level_full", 32'(level), 32'd8);
    check("t3_overflow", 32'(overflow), 32'd1);
    pulse_start();
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      {e_tone, e_vol, e_dur} = e;
      check("t3_load_state", 32'(dbg_state), 32'(S_LOAD));
      step(1);
      check("t3_tone", 32'(tone_div), 32'(e_tone));
      check("t3_vol", 32'(vol), 32'(e_vol));
      check("t3_level", 32'(level), 32'(7 - k));
      step(4 * int'(e_dur));
      check("t3_gap_vol", 32'(vol), 32'd0);
      check("t3_gap_state", 32'(dbg_state), 32'(S_GAP));
      step(4);
      if (note_done === 1'b1) done_cnt++;
    end
    check("t3_note_done_count", done_cnt, 8);
    check("t3_final_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4. stop during first PLAY
    push_note(14'd400, 16'h3333, 8'd3);
    push_note(14'd401, 16'h4444, 8'd3);
    pulse_start();
    step(3);
    check("t4_playing", 32'(vol), 32'h3333);
    pulse_stop();
    check("t4_vol", 32'(vol), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_level", 32'(level), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_overflow_cleared", 32'(overflow), 32'd0);
    check("t4_state", 32'(dbg_state), 32'(S_IDLE));
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (note_done === 1'b1) done_cnt++;
      step(1);
    end
    check("t4_no_note_done", done_cnt, 0);
    pulse_start();
    check("t4_start_empty_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t4_start_empty_busy", 32'(busy), 32'd0);

    // 5. push during LOAD, dur=0 note
    push_note(14'd300, 16'h7777, 8'd0);
    pulse_start();
    check("t5_load", 32'(dbg_state), 32'(S_LOAD));
    push_note(14'd301, 16'h1111, 8'd1);
    check("t5_level_unchanged", 32'(level), 32'd1);
    check("t5_tone", 32'(tone_div), 32'd300);
    check("t5_vol", 32'(vol), 32'h7777);
    step(1023);
    check("t5_still_play", 32'(dbg_state), 32'(S_PLAY));
    check("t5_vol_end", 32'(vol), 32'h7777);
    step(1);
    check("t5_gap", 32'(dbg_state), 32'(S_GAP));
    check("t5_gap_vol", 32'(vol), 32'd0);
    step(4);
    check("t5_note_done", 32'(note_done), 32'd1);
    check("t5_next_load", 32'(dbg_state), 32'(S_LOAD));
    step(1);
    check("t5_second_tone", 32'(tone_div), 32'd301);
    check("t5_second_vol", 32'(vol), 32'h1111);
    check("t5_level_zero", 32'(level), 32'd0);
    pulse_stop();
    check("t5_stopped", 32'(dbg_state), 32'(S_IDLE));

    // 6. start and stop together (plus a write that stop must drop)
    push_note(14'd500, 16'h5555, 8'd2);
    check("t6_level_one", 32'(level), 32'd1);
    start = 1'b1; stop = 1'b1;
    wr_en = 1'b1; wr_tone_div = 14'd501; wr_vol = 16'h6666; wr_dur = 8'd1;
    step(1);
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    step(2);
    check("t6_still_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t6_vol", 32'(vol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
